// File: rtl/imem_access_arbiter.sv
// Arbitrates the single-ported instruction memory between IF-stage fetch and the boot loader.
// Boot phase gives the loader exclusive access; run phase favours fetch with a loader starvation guard.
module imem_access_arbiter #(
   parameter int ADDR_W        = 10,
   parameter int MAX_WAIT      = 4,
   parameter bit BOOT_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_stall,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_fault,
   input  logic              load_req,
   input  logic [31:0]       load_addr,
   input  logic [31:0]       load_data,
   output logic              load_ack,
   input  logic              load_done,
   output logic              boot_mode,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic {BOOT, RUN} state_t;
   localparam state_t RST_STATE = BOOT_ON_RESET ? BOOT : RUN;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic          rd_pend;
   logic          fault_q;

   logic fetch_ok, load_ok, force_load;
   logic fetch_grant, load_grant;
   logic unused_load_lsbs;

   assign unused_load_lsbs = ^load_addr[1:0];

   assign fetch_ok   = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:ADDR_W+2] == '0);
   assign load_ok    = (load_addr[31:ADDR_W+2] == '0);
   assign force_load = load_req && (wait_cnt == WW'(MAX_WAIT));

   always_comb begin
      fetch_grant = 1'b0;
      load_grant  = 1'b0;
      if (!reset) begin
         if (state == BOOT) begin
            load_grant = load_req;
         end else begin
            fetch_grant = fetch_req && !force_load;
            load_grant  = load_req && (!fetch_req || force_load);
         end
      end
   end

   assign load_ack    = load_grant;
   assign fetch_stall = !reset && fetch_req && !fetch_grant;
   assign mem_we      = load_grant && load_ok;
   assign mem_en      = mem_we || (fetch_grant && fetch_ok);
   assign mem_addr    = load_grant ? load_addr[ADDR_W+1:2] : fetch_addr[ADDR_W+1:2];
   assign mem_wdata   = load_data;
   assign boot_mode   = (state == BOOT);

   // A read landing during a reset cycle is discarded so no stale instruction escapes.
   assign fetch_valid = rd_pend && !reset;
   assign fetch_instr = fetch_valid ? mem_rdata : '0;
   assign fetch_fault = fault_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RST_STATE;
         wait_cnt <= '0;
         rd_pend  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         rd_pend <= fetch_grant && fetch_ok;
         fault_q <= fetch_grant && !fetch_ok;
         if (!load_req || load_grant)
            wait_cnt <= '0;
         else if (wait_cnt != WW'(MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;
         if (state == BOOT && load_done)
            state <= RUN;
      end
   end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Randomized bench for imem_access_arbiter against a cycle-level behavioural model.
module tb_imem_access_arbiter;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
   localparam int MAXW  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic          fetch_stall, fetch_valid, fetch_fault;
   logic [31:0]   fetch_instr;
   logic          load_req;
   logic [31:0]   load_addr, load_data;
   logic          load_ack, load_done, boot_mode;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   logic [31:0] mem [DEPTH];

   int total = 0;
   int bad   = 0;

   // model state
   bit          m_boot;
   int          m_wait;
   bit          e_valid, e_fault;
   logic [31:0] e_instr;
   logic [31:0] ref_mem [DEPTH];

   imem_access_arbiter #(.ADDR_W(AW), .MAX_WAIT(MAXW), .BOOT_ON_RESET(1'b1)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
      .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
      .load_ack(load_ack), .load_done(load_done), .boot_mode(boot_mode),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one cycle of inputs (called just after a falling edge), checks, advances the model.
   task automatic step(input bit r, input bit fr, input logic [31:0] fa,
                       input bit lr, input logic [31:0] la, input logic [31:0] ld,
                       input bit done, output bit acked);
      bit fg, lg, force_l, f_ok, l_ok, e_en, e_we;
      reset = r; fetch_req = fr; fetch_addr = fa;
      load_req = lr; load_addr = la; load_data = ld; load_done = done;
      #1;
      f_ok = (fa % 4 == 0) && ((fa >> 2) < DEPTH);
      l_ok = (la >> 2) < DEPTH;
      fg = 0; lg = 0;
      if (!r) begin
         if (m_boot) lg = lr;
         else begin
            force_l = lr && (m_wait >= MAXW);
            fg = fr && !force_l;
            lg = lr && (!fr || force_l);
         end
      end
      e_we = lg && l_ok;
      e_en = e_we || (fg && f_ok);
      check("boot_mode",   32'(boot_mode),   32'(m_boot));
      check("fetch_valid", 32'(fetch_valid), r ? 32'd0 : 32'(e_valid));
      check("fetch_instr", fetch_instr,      (r || !e_valid) ? 32'd0 : e_instr);
      check("fetch_fault", 32'(fetch_fault), 32'(e_fault));
      check("load_ack",    32'(load_ack),    32'(lg));
      check("fetch_stall", 32'(fetch_stall), 32'(!r && fr && !fg));
      check("mem_en",      32'(mem_en),      32'(e_en));
      check("mem_we",      32'(mem_we),      32'(e_we));
      if (e_en) check("mem_addr", 32'(mem_addr), lg ? (la >> 2) : (fa >> 2));
      if (e_we) check("mem_wdata", mem_wdata, ld);
      acked = lg;
      if (r) begin
         m_boot = 1; m_wait = 0; e_valid = 0; e_fault = 0; e_instr = '0;
      end else begin
         e_valid = fg && f_ok;
         e_fault = fg && !f_ok;
         e_instr = (fg && f_ok) ? ref_mem[fa >> 2] : '0;
         if (e_we) ref_mem[la >> 2] = ld;
         if (!lr || lg) m_wait = 0;
         else if (m_wait < MAXW) m_wait++;
         if (m_boot && done) m_boot = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      bit ack;
      bit hold_lr;
      logic [31:0] hold_la, hold_ld, fa, la;
      bit r, fr, done;
      int k;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      mem_rdata = '0;
      reset = 1; fetch_req = 0; fetch_addr = '0; load_req = 0;
      load_addr = '0; load_data = '0; load_done = 0;
      m_boot = 1; m_wait = 0; e_valid = 0; e_fault = 0; e_instr = '0;
      @(negedge clk); @(negedge clk);

      // reset state, then boot load with a fetch attempted during BOOT
      step(1, 0, 0, 0, 0, 0, 0, ack);
      step(0, 1, 32'h0, 1, 32'h0, 32'h0000_0013, 0, ack);
      step(0, 0, 32'h0, 1, 32'h4, 32'h0010_0093, 0, ack);
      step(0, 0, 32'h0, 1, 32'h1000, 32'hdead_beef, 0, ack);
      // write and load_done together: write must land, state goes to RUN
      step(0, 0, 32'h0, 1, 32'hC, 32'h1234_5678, 1, ack);
      // fetches after boot, back-to-back
      step(0, 1, 32'h4, 0, 0, 0, 0, ack);
      step(0, 1, 32'h0, 0, 0, 0, 0, ack);
      step(0, 1, 32'h4, 0, 0, 0, 0, ack);
      step(0, 1, 32'hC, 0, 0, 0, 1, ack);
      // starvation guard: loader to 0x8 denied four cycles, forced on the fifth
      for (int i = 0; i < 6; i++) step(0, 1, 32'h0, 1, 32'h8, 32'hcafe_f00d, 0, ack);
      step(0, 1, 32'h8, 0, 0, 0, 0, ack);
      // faults
      step(0, 1, 32'h2, 0, 0, 0, 0, ack);
      step(0, 1, 32'h1000, 0, 0, 0, 0, ack);
      step(0, 0, 32'h0, 1, 32'h1000, 32'h5555_aaaa, 0, ack);
      step(0, 0, 32'h0, 0, 0, 0, 0, ack);
      // reset mid-fetch
      step(0, 1, 32'h4, 0, 0, 0, 0, ack);
      step(1, 1, 32'h4, 0, 0, 0, 0, ack);
      step(0, 1, 32'h4, 0, 0, 0, 0, ack);

      // randomized traffic; loader holds its request until acknowledged
      hold_lr = 0; hold_la = '0; hold_ld = '0;
      for (int c = 0; c < 3000; c++) begin
         r    = ($urandom_range(0, 59) == 0);
         done = ($urandom_range(0, 24) == 0);
         fr   = ($urandom_range(0, 9) < 6);
         k    = $urandom_range(0, 99);
         if (k < 85)      fa = 32'($urandom_range(0, 15)) << 2;
         else if (k < 93) fa = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
         else             fa = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
         if (!hold_lr && $urandom_range(0, 9) < 4) begin
            hold_lr = 1;
            la = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 4095))
                                             : (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            hold_la = la;
            hold_ld = $urandom;
         end
         step(r, fr, fa, hold_lr, hold_la, hold_ld, done, ack);
         if (ack || r) hold_lr = 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares the single-ported 1024-word instruction memory between two requesters: the IF-stage fetch port and the boot/program loader write port.
- Sequences the boot phase: fetch is held off until the loader signals image complete.
- At run time, fetch has priority, with a starvation guard for loader writes.
- Sits between the PC/IF stage and the instruction memory array.

Parameters:
- ADDR_W, 10: word-index width; memory depth is 2^ADDR_W words.
- MAX_WAIT, 4: consecutive denied loader cycles in RUN before the loader is forced a grant.
- BOOT_ON_RESET, 1: 1 = reset enters BOOT; 0 = reset enters RUN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  IF stage requests an instruction.
- fetch_addr  in  32  byte address of the instruction.
- fetch_stall  out  1  fetch_req present but not granted this cycle (combinational).
- fetch_valid  out  1  fetch_instr valid (registered; cycle after grant).
- fetch_instr  out  32  fetched instruction; 0 when fetch_valid=0.
- fetch_fault  out  1  one-cycle pulse; previous-cycle fetch was misaligned or out of range.
- load_req  in  1  loader write request; hold until load_ack.
- load_addr  in  32  byte address; bits [1:0] ignored.
- load_data  in  32  write data.
- load_ack  out  1  write granted this cycle (combinational).
- load_done  in  1  loader image complete.
- boot_mode  out  1  1 while in BOOT.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid the cycle after a read access.

Behaviour:
- Reset values:
  - state = BOOT (or RUN if BOOT_ON_RESET=0); boot_mode matches state.
  - fetch_valid=0, fetch_fault=0, fetch_instr=0, wait_cnt=0.
  - During any reset cycle, mem_en, mem_we, load_ack and fetch_stall are forced 0.
- Grant timing:
  - Grant is decided combinationally in cycle N; mem_* driven in N; memory samples at the N→N+1 edge.
  - Read data appears in N+1: fetch_valid=1 and fetch_instr=mem_rdata in N+1.
- Fetch address check:
  - Legal when fetch_addr[1:0]==0 and fetch_addr[31:2] < 2^ADDR_W.
  - mem_addr = fetch_addr[ADDR_W+1:2].
  - Illegal fetch: granted with no memory access (mem_en=0), fetch_stall=0, fetch_fault=1 and fetch_valid=0 in N+1.
- BOOT state:
  - Loader granted whenever load_req: mem_en=1, mem_we=1, load_ack=1.
  - fetch_stall = fetch_req; no reads are issued.
  - load_done=1 → RUN at the next edge. A write granted in the same cycle still completes.
- RUN state:
  - Default priority to fetch; loader granted only when fetch_req=0.
  - wait_cnt increments (saturating at MAX_WAIT) each cycle load_req is denied; it clears on loader grant or when load_req=0.
  - When wait_cnt==MAX_WAIT and load_req=1, the loader is granted: fetch_stall=1 and no fetch_valid in N+1.
  - load_done is ignored in RUN.
- Loader out-of-range address (load_addr[31:2] ≥ 2^ADDR_W):
  - load_ack still asserted; mem_en=0, mem_we=0; write dropped.
- Back-to-back fetches: one grant per cycle, so fetch_valid can be high every cycle.
- Simultaneous fetch_req and load_req:
  - BOOT → loader wins.
  - RUN → fetch wins unless wait_cnt==MAX_WAIT.
- Reset mid-operation:
  - A pending read is cancelled; fetch_valid=0 in the cycle after reset even if a read was granted before it.
  - wait_cnt clears; state returns to its reset value.
- Only one memory operation per cycle; mem_we=1 implies mem_en=1.

Test Plan:
- Boot load: reset, then loader writes 0x00000013 to byte addr 0x0 and 0x00100093 to 0x4, then load_done → load_ack each cycle, boot_mode drops after load_done; a fetch during BOOT sees fetch_stall=1.
- Fetch after boot: fetch_addr=0x4 in cycle N → fetch_valid=1, fetch_instr=0x00100093 in N+1; consecutive fetches of 0x0 and 0x4 give valid on two successive cycles.
- Starvation: in RUN, hold fetch_req=1 continuously with load_req=1 to 0x8 → loader denied 4 cycles, granted on the 5th with fetch_stall=1 in that cycle only; readback of 0x8 returns load_data.
- Faults: fetch_addr=0x2 → fetch_fault pulse, fetch_valid=0, mem_en=0; fetch_addr=0x1000 (word 1024) → fetch_fault; load_addr=0x1000 → load_ack=1, mem_we=0.
- Simultaneous: load_req and load_done in the same BOOT cycle → write committed and state=RUN next cycle; fetch and load in the same RUN cycle with wait_cnt=0 → fetch granted.
- Reset mid-fetch: grant fetch in N, assert reset in N+1 → fetch_valid=0, boot_mode=1, mem_en=0 during reset.
